// File: rtl/nibble_chain_pkg.sv
// Shared types and the slice-add helper for the beat-serial chain adder.
// The helper works at a fixed maximum width so any slice width up to SLICE_W_MAX can reuse it.
package nibble_chain_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MAX_BEATS_LIMIT = 255;
  localparam int CNT_W           = $clog2(MAX_BEATS_LIMIT + 1);
  localparam int SLICE_W_MAX     = 32;

  // Returns {carry, sum}; callers zero-extend their operands and truncate the result.
  function automatic logic [SLICE_W_MAX:0] add_slice(
    input logic [SLICE_W_MAX-1:0] a,
    input logic [SLICE_W_MAX-1:0] b,
    input logic                   cin
  );
    add_slice = {1'b0, a} + {1'b0, b} + {{SLICE_W_MAX{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/nibble_chain_adder_slice_adder.sv
// Combinational W-bit slice add with carry-in/out and an optional subtract (invert-B) path.
// o_carry is the true adder carry; o_cout is what the block reports (borrow when subtracting).
module slice_adder
  import nibble_chain_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_sub,
  output logic [W-1:0] o_s,
  output logic         o_carry,
  output logic         o_cout
);

  logic [W-1:0] w_b;

  assign w_b = i_sub ? ~i_b : i_b;

  assign {o_carry, o_s} = (W + 1)'(add_slice(SLICE_W_MAX'(i_a), SLICE_W_MAX'(w_b), i_cin));

  assign o_cout = i_sub ? ~o_carry : o_carry;

endmodule

// File: rtl/nibble_chain_adder.sv
// Beat-serial multi-word adder: one W-bit slice per beat, LSB first, carry held between beats.
// Define NIBBLE_CHAIN_ADDER_SUB_EN to add the 'sub' port (subtract with Cin/Cout as borrow).
module nibble_chain_adder
  import nibble_chain_pkg::*;
#(
  parameter int W         = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         out_last,
  output logic         err
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_err;
  logic             r_out_valid;
  logic [W-1:0]     r_s;
  logic             r_cout;
  logic             r_last;

  state_t           w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_carry_n;
  logic             w_sub_n;
  logic             w_err_n;
  logic             w_force_last;
  logic             w_accept;
  logic             w_orphan;
  logic             w_sub_in;
  logic             w_sub_eff;
  logic             w_cin;
  logic [W-1:0]     w_s;
  logic             w_carry;
  logic             w_cout;

`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign in_ready = rst_n & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // A non-first beat arriving while idle has no carry history: it is added with cin=0.
  assign w_orphan  = ~in_first & (r_state == IDLE);
  assign w_sub_eff = in_first ? w_sub_in : (w_orphan ? 1'b0 : r_sub);
  assign w_cin     = in_first ? (w_sub_in ? ~Cin : Cin) : (w_orphan ? 1'b0 : r_carry);

  slice_adder #(
    .W(W)
  ) u_slice_adder (
    .i_a    (A),
    .i_b    (B),
    .i_cin  (w_cin),
    .i_sub  (w_sub_eff),
    .o_s    (w_s),
    .o_carry(w_carry),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_carry_n    = r_carry;
    w_sub_n      = r_sub;
    w_err_n      = r_err;
    w_force_last = 1'b0;
    if (w_accept) begin
      if (in_first) begin
        w_sub_n = w_sub_in;
        w_cnt_n = CNT_W'(1);
        if (r_state == ACTIVE) begin
          w_err_n = 1'b1;
        end
      end else if (r_state == IDLE) begin
        w_sub_n = 1'b0;
        w_cnt_n = CNT_W'(1);
        w_err_n = 1'b1;
      end else begin
        w_cnt_n = r_cnt + CNT_W'(1);
        // Operand overran MAX_BEATS without a last marker: close it out here.
        if (!in_last && (w_cnt_n == CNT_W'(MAX_BEATS))) begin
          w_err_n      = 1'b1;
          w_force_last = 1'b1;
        end
      end
      if (in_last || w_force_last) begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
        w_carry_n = 1'b0;
      end else begin
        w_state_n = ACTIVE;
        w_carry_n = w_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_carry <= w_carry_n;
      r_sub   <= w_sub_n;
      r_err   <= w_err_n;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_s         <= w_s;
        r_cout      <= w_cout;
        r_last      <= in_last | w_force_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign Cout      = r_cout;
  assign out_last  = r_last;
  assign err       = r_err;

endmodule

// File: tb/tb_nibble_chain_adder.sv
// Self-checking bench for nibble_chain_adder: directed vector table, corner-case sequences,
// and a randomized stream checked against whole-operand integer arithmetic.
module tb_nibble_chain_adder;

  localparam int W    = 4;
  localparam int MAXB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic         in_last;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         out_last;
  logic         err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         first;
    logic         last;
    logic         sb;
    logic [W-1:0] expS;
    logic         expCout;
    logic         expLast;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         first;
    logic         last;
  } beat_t;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         last;
  } res_t;

  vec_t  vecs[$];
  beat_t beatQ[$];
  res_t  expQ[$];

  always #5 clk = ~clk;

  nibble_chain_adder #(
    .W(W),
    .MAX_BEATS(MAXB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_last  (in_last),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout),
    .out_last (out_last),
    .err      (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic f, input logic l);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    in_first = f;
    in_last  = l;
  endtask

  function automatic void addVec(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic f, input logic l, input logic sb,
                                 input logic [W-1:0] es, input logic ec, input logic el);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.cin = cin; v.first = f; v.last = l; v.sb = sb;
    v.expS = es; v.expCout = ec; v.expLast = el;
    vecs.push_back(v);
  endfunction

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
    sub = 1'b0;
`endif
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkBeat(input string nm, input logic [W-1:0] es, input logic ec,
                           input logic el, input logic ee);
    checkOutput({nm, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({nm, " S"}, 32'(S), 32'(es));
    checkOutput({nm, " Cout"}, 32'(Cout), 32'(ec));
    checkOutput({nm, " out_last"}, 32'(out_last), 32'(el));
    checkOutput({nm, " err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    // Directed vectors, streamed back-to-back with out_ready held high.
    addVec("single E+C",   4'hE, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1);
    addVec("ripple b0",    4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    addVec("ripple b1",    4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
    addVec("single cin1",  4'h7, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    addVec("three b0",     4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    addVec("three b1",     4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    addVec("three b2",     4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    addVec("fresh cin",    4'h3, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0, 4'h8, 1'b0, 1'b1);
    addVec("two cin1 b0",  4'h8, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    addVec("two cin1 b1",  4'h2, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b1);
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
    addVec("sub 6-B",      4'h6, 4'hB, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB, 1'b1, 1'b1);
    addVec("sub 5-5-1",    4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
    addVec("sub 10-01 b0", 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    addVec("sub 10-01 b1", 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
`endif

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
    sub = 1'b0;
`endif
    out_ready = 1'b1;
    #3;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset S", 32'(S), 32'd0);
    checkOutput("reset Cout", 32'(Cout), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    doReset();
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].first, vecs[i].last);
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
      sub = vecs[i].sb;
`endif
      @(negedge clk);
      checkBeat(vecs[i].name, vecs[i].expS, vecs[i].expCout, vecs[i].expLast, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
`ifdef NIBBLE_CHAIN_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk);
    checkOutput("drop after handshake", 32'(out_valid), 32'd0);

    // Beat without first while idle: flagged, processed with cin=0, carry chain continues.
    applyStimulus(1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkBeat("orphan", 4'h7, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'h9, 4'h9, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkBeat("orphan tail", 4'h2, 1'b1, 1'b1, 1'b1);

    // Operand running past MAX_BEATS without last.
    doReset();
    for (int i = 0; i < MAXB; i++) begin
      applyStimulus(1'b1, 4'hF, 4'h0, 1'b1, (i == 0), 1'b0);
      @(negedge clk);
      checkBeat($sformatf("overrun beat%0d", i), 4'h0, 1'b1, (i == MAXB - 1), (i == MAXB - 1));
    end
    applyStimulus(1'b1, 4'h1, 4'h1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkBeat("after overrun", 4'h2, 1'b0, 1'b1, 1'b1);

    // First marker in the middle of an operation restarts with the new Cin.
    doReset();
    applyStimulus(1'b1, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("restart b0", 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 4'h2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkBeat("restart b1", 4'h4, 1'b0, 1'b1, 1'b1);

    // Backpressure: output held, input stalled, then back-to-back release.
    doReset();
    applyStimulus(1'b1, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("bp b0", 4'h0, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp stall%0d in_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
      checkBeat($sformatf("bp hold%0d", i), 4'h0, 1'b1, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkBeat("bp b1", 4'h1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h8, 4'h8, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkBeat("bp no bubble", 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp drain", 32'(out_valid), 32'd0);

    // Reset in the middle of an operation discards the partial result.
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'h5, 4'h5, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkBeat("midreset new op", 4'hA, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Random legal operations vs whole-operand arithmetic.
    doReset();
    for (int op = 0; op < 60; op++) begin
      int unsigned n;
      longint unsigned opA, opB, full, part, mask;
      logic cin;
      n    = $urandom_range(1, MAXB);
      mask = (64'd1 << (4 * n)) - 64'd1;
      opA  = {32'd0, $urandom} & mask;
      opB  = {32'd0, $urandom} & mask;
      cin  = 1'($urandom_range(0, 1));
      full = opA + opB + 64'(cin);
      for (int i = 0; i < int'(n); i++) begin
        beat_t bt;
        res_t  rs;
        mask     = (64'd1 << (4 * (i + 1))) - 64'd1;
        part     = (opA & mask) + (opB & mask) + 64'(cin);
        bt.a     = 4'((opA >> (4 * i)) & 64'hF);
        bt.b     = 4'((opB >> (4 * i)) & 64'hF);
        bt.cin   = cin;
        bt.first = (i == 0);
        bt.last  = (i == int'(n) - 1);
        rs.s     = 4'((full >> (4 * i)) & 64'hF);
        rs.cout  = 1'((part >> (4 * (i + 1))) & 64'd1);
        rs.last  = bt.last;
        beatQ.push_back(bt);
        expQ.push_back(rs);
      end
    end
    @(negedge clk);
    begin
      int cycles = 0;
      int idx    = 0;
      while (expQ.size() > 0 && cycles < 5000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (beatQ.size() > 0 && $urandom_range(0, 4) != 0)
          applyStimulus(1'b1, beatQ[0].a, beatQ[0].b, beatQ[0].cin, beatQ[0].first, beatQ[0].last);
        else
          applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        if (out_valid && out_ready) begin
          checkOutput($sformatf("rand%0d S", idx), 32'(S), 32'(expQ[0].s));
          checkOutput($sformatf("rand%0d Cout", idx), 32'(Cout), 32'(expQ[0].cout));
          checkOutput($sformatf("rand%0d out_last", idx), 32'(out_last), 32'(expQ[0].last));
          void'(expQ.pop_front());
          idx++;
        end
        if (in_valid && in_ready) void'(beatQ.pop_front());
        @(negedge clk);
        cycles++;
      end
      checkOutput("rand results outstanding", 32'(expQ.size()), 32'd0);
      checkOutput("rand err", 32'(err), 32'd0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_chain_adder.md
Name: nibble_chain_adder

Overview:
- Beat-serial multi-word adder, the addition counterpart of the team's 4-bit borrow-chained subtractor.
- Accepts one W-bit slice of each operand per beat, LSB slice first.
- Carry is held in a register between beats, so long operands (up to MAX_BEATS slices) are added without an external carry feedback loop.
- Sits between an operand-slicing source and a result collector; valid/ready on both sides.

Parameters:
- W, 4, slice width in bits.
- MAX_BEATS, 8, maximum slices per operand; 2..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input slice present.
- in_ready  out  1  block can accept a slice this cycle.
- in_first  in  1  slice is the least-significant slice of a new operation.
- in_last  in  1  slice is the most-significant slice.
- A  in  W  augend slice.
- B  in  W  addend slice.
- Cin  in  1  carry-in; sampled only on a first beat.
- out_valid  out  1  result slice present.
- out_ready  in  1  downstream accepts the result slice.
- S  out  W  sum slice.
- Cout  out  1  carry out of this slice; final carry when out_last=1.
- out_last  out  1  result slice is the final slice.
- err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset values: in_ready=0 while rst_n=0, then 1. out_valid=0, S=0, Cout=0, out_last=0, err=0, carry_q=0, beat_cnt=0, state=IDLE.
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready, which gives a single output register with pass-through ready.
- Per accepted beat: cin = (in_first ? Cin : carry_q). {c,s} = A + B + cin computed at W+1 bits. Next cycle: S=s, Cout=c, out_last=in_last, out_valid=1. Latency is 1 cycle.
- carry_q <= c on every accepted beat. carry_q <= 0 on an accepted beat with in_last=1.
- Output holds stable while out_valid && !out_ready. out_valid drops after handshake if no new beat is accepted the same cycle.
- FSM:
  - IDLE: accepted beat with in_first → ACTIVE, beat_cnt=1. If in_first && in_last, stay IDLE (single-slice op).
  - IDLE: accepted beat without in_first → err=1; the beat is still processed with cin=0 and the block enters ACTIVE.
  - ACTIVE: accepted beat with in_last → IDLE, beat_cnt=0.
  - ACTIVE: accepted beat with in_first → restart; err=1; carry uses Cin; beat_cnt=1.
  - ACTIVE: beat_cnt reaching MAX_BEATS without in_last → err=1. That beat is forced to out_last=1, carry is cleared, FSM goes to IDLE.
- Simultaneous out handshake and new accept: out regs reload, out_valid stays 1, no bubble.
- rst_n asserted mid-operation: all state cleared immediately; a partial result is discarded and never completed.

Optional Feature:
- Macro: NIBBLE_CHAIN_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), sampled on the first beat and latched for the operation.
  - When latched sub=1: s = A + ~B + cin, where cin = first ? ~Cin : carry_q.
  - Cout is reported as borrow (inverted carry), so Cin/Cout act as Bin/Bout.
  - sub is ignored on non-first beats.
- Undefined: no sub port; add only.

Decomposition:
- Shared package nibble_chain_pkg:
  - state enum (IDLE, ACTIVE).
  - localparam CNT_W = $clog2(MAX_BEATS+1).
  - function add_slice(a, b, cin) returning {c,s}.
- One natural sub-module: slice_adder, the combinational W-bit add with carry-in/out (and the invert path when SUB_EN). The FSM, counter and output register stay in the top.

Test Plan:
- Single slice: first=last=1, A=4'hE, B=4'hC, Cin=0 → S=4'hA, Cout=1, out_last=1, one cycle after accept.
- Two-slice ripple: beat0 A=F B=1 Cin=0, beat1 A=0 B=0 last → S0=0 Cout0=1; S1=1 Cout1=0 (0x0F+0x01=0x10).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, S/Cout stable; release → back-to-back beats, no bubble, no lost carry.
- Protocol errors:
  - Beat without first in IDLE → err=1, beat still output.
  - MAX_BEATS=8 slices with no last → 8th output has out_last=1, err=1.
- Mid-op reset: after 2 of 4 beats, pulse rst_n low → out_valid=0, carry_q=0; new op 5+5 with Cin=0 gives S=A, Cout=0.
- SUB_EN build: sub=1, A=6 B=B Cin(Bin)=0 → S=B (4'hB), Cout=1; A=5 B=5 Bin=1 → S=F, Cout=1.
